// File: rtl/arb_mux_reg.sv
// N-channel mux (explicit select or round-robin) into one registered output word; 1-cycle latency.
// Backpressure: inputs are granted only while the output register is empty or draining this cycle.
module arb_mux_reg #(
   parameter  int WIDTH = 32,
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        select,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   input  logic [N_CH-1:0]         in_valid,
   output logic [N_CH-1:0]         in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   output logic                    out_valid,
   input  logic                    out_ready
);

   typedef struct packed {
      logic [SEL_W-1:0] ch;
      logic [WIDTH-1:0] dat;
   } word_t;

   word_t             out_q;
   logic [SEL_W-1:0]  ptr;
   logic [N_CH-1:0]   grant;
   logic [SEL_W-1:0]  gnt_idx;
   logic [WIDTH-1:0]  gnt_dat;
   logic              found;
   logic              load_en;

   assign load_en = !out_valid | out_ready;

   // Grant is one-hot or zero; gnt_idx/gnt_dat only matter when a grant bit is set.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_dat = '0;
      found   = 1'b0;
      if (!mode) begin
         for (int i = 0; i < N_CH; i++) begin
            if (select == SEL_W'(i)) begin
               grant[i] = in_valid[i];
               gnt_idx  = SEL_W'(i);
               gnt_dat  = in_data[i*WIDTH +: WIDTH];
            end
         end
      end else begin
         // Scan starts just past the last winner so a busy channel cannot starve the others.
         for (int k = 1; k <= N_CH; k++) begin
            if (!found && in_valid[(int'(ptr) + k) % N_CH]) begin
               found                            = 1'b1;
               grant[(int'(ptr) + k) % N_CH]    = 1'b1;
               gnt_idx                          = SEL_W'((int'(ptr) + k) % N_CH);
               gnt_dat                          = in_data[((int'(ptr) + k) % N_CH)*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign in_ready = grant & {N_CH{load_en & ~rst}};

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         out_valid <= 1'b0;
         ptr       <= SEL_W'(N_CH - 1);
      end else begin
         if (|in_ready) begin
            out_q     <= '{ch: gnt_idx, dat: gnt_dat};
            out_valid <= 1'b1;
            if (mode) begin
               ptr <= gnt_idx;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign out_data = out_q.dat;
   assign out_ch   = out_q.ch;

endmodule

// File: doc/arb_mux_reg.md
Name: arb_mux_reg

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output and valid/ready handshakes on every channel.
- Two selection modes:
  - explicit select: a generalised successor to the combinational 4:1 datapath mux;
  - round-robin arbitration: for sharing one consumer between several producers, e.g. memory port, writeback bus or register-file write port.
- Sits between N producers and one consumer.
- Provides a one-cycle registered boundary that breaks the combinational path.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N_CH, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N_CH), width of select/channel index. Derived localparam; not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = explicit select, 1 = round-robin arbitration.
- select  input  SEL_W  channel index used when mode=0.
- in_data  input  N_CH*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  channel i has a word to transfer.
- in_ready  output  N_CH  channel i word is accepted this cycle (at most one bit set).
- out_data  output  WIDTH  registered output word.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch hold a valid word.
- out_ready  input  1  consumer accepts the output word this cycle.

Behaviour:
- Reset, synchronous on rst=1 at the clock edge:
  - out_valid=0, out_data=0, out_ch=0;
  - RR pointer ptr=N_CH-1, so channel 0 has first priority;
  - rst overrides all other activity in the same cycle;
  - a word held mid-transfer is discarded.
- Load enable: load_en = !out_valid | out_ready. The single output register may accept a new word when it is empty or being drained in the same cycle.
- Grant, combinational, one-hot or zero:
  - mode=0: grant[select] = in_valid[select]. If select >= N_CH, there is no grant.
  - mode=1: first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... modulo N_CH. Wraps from N_CH-1 to 0. Zero when no in_valid is set.
- in_ready[i] = grant[i] & load_en & !rst. in_ready depends on in_valid, so producers must not make in_valid depend on in_ready.
- Transfer into the block: in_valid[i] & in_ready[i]. On that edge:
  - out_data <= channel i data;
  - out_ch <= i;
  - out_valid <= 1.
- Transfer out: out_valid & out_ready.
  - If no new grant occurs in the same cycle, out_valid <= 0; out_data and out_ch hold their last values.
  - Simultaneous drain and load gives back-to-back words with no bubble.
- Stall: out_valid=1 & out_ready=0 → all in_ready=0 and out_data/out_ch/out_valid are held stable.
- Latency: accepted word appears on out_data the cycle after acceptance. Throughput is 1 word/cycle.
- RR pointer:
  - ptr <= i only on an accepted transfer while mode=1;
  - unchanged in mode=0 and on cycles with no transfer.
  - Result: a continuously requesting channel cannot be granted twice while another channel is waiting.
- Mode/select changes take effect combinationally in the same cycle. A word already held in the output register is unaffected.
- Data is passed through unmodified: no width conversion, no arithmetic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000. Release rst with mode=1, out_ready=1 → first grant is ch0.
- Explicit select: mode=0, select=2, in_valid=1111, ch2 data=0xDEADBEEF, out_ready=1:
  - in_ready=0100;
  - next cycle out_data=0xDEADBEEF, out_ch=2, out_valid=1.
  - Then set select=1 with in_valid=1101 → in_ready=0000 and out_valid drops to 0 after the drain.
- Round-robin fairness: mode=1, in_valid=1111 held, out_ready=1, channel i data=0x100+i for 8 cycles:
  - out_ch sequence 0,1,2,3,0,1,2,3;
  - out_data follows as 0x100..0x103 repeated;
  - no idle cycles.
- Skip and wrap: mode=1, ptr=2 (ch2 last granted), in_valid=0011 → ch0 granted next, then ch1, then ch0.
- Backpressure: out_valid=1 holding 0xA5A5A5A5, out_ready=0 for 3 cycles with in_valid=1111:
  - in_ready=0000 throughout and out_data remains 0xA5A5A5A5;
  - out_ready=1 → the drain and the next load happen in the same cycle.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0 → out_valid=0 next cycle. The first post-reset grant in mode=1 is the lowest requesting channel.
